// File: rtl/register_file_mp.sv
// Multi-port integer register file with two write ports, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module register_file_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned BYPASS = 1,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     read_addr,
   output logic [NUM_RD*XLEN-1:0]   read_data,
   output logic [NUM_RD-1:0]        read_busy,
   input  logic                     wa_enable,
   input  logic [AW-1:0]            wa_addr,
   input  logic [XLEN-1:0]          wa_data,
   input  logic                     wb_enable,
   input  logic [AW-1:0]            wb_addr,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     alloc_enable,
   input  logic [AW-1:0]            alloc_addr,
   output logic [NREGS-1:0]         busy_vec
);

   logic [XLEN-1:0] regs [1:NREGS-1];
   logic [NREGS-1:1] busy_q;

   logic wa_live;
   logic wb_live;
   assign wa_live = wa_enable && (wa_addr != '0);
   assign wb_live = wb_enable && (wb_addr != '0);

   // Data storage: port B wins a same-address collision, x0 has no storage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 1; r < int'(NREGS); r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int r = 1; r < int'(NREGS); r++) begin
            if (wb_enable && (wb_addr == AW'(r))) begin
               regs[r] <= wb_data;
            end else if (wa_enable && (wa_addr == AW'(r))) begin
               regs[r] <= wa_data;
            end
         end
      end
   end

   // Scoreboard: a new allocation supersedes a retiring producer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         for (int r = 1; r < int'(NREGS); r++) begin
            busy_q[r] <= (alloc_enable && (alloc_addr == AW'(r))) ||
                         (busy_q[r] && !((wa_enable && (wa_addr == AW'(r))) ||
                                         (wb_enable && (wb_addr == AW'(r)))));
         end
      end
   end

   assign busy_vec = {busy_q, 1'b0};

   // Combinational read ports; address 0 falls through to the zero defaults.
   always_comb begin
      read_data = '0;
      read_busy = '0;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         for (int r = 1; r < int'(NREGS); r++) begin
            if (read_addr[i*AW +: AW] == AW'(r)) begin
               read_data[i*XLEN +: XLEN] = regs[r];
               read_busy[i]              = busy_q[r];
            end
         end
         if (BYPASS != 0) begin
            if (wa_live && (wa_addr == read_addr[i*AW +: AW])) begin
               read_data[i*XLEN +: XLEN] = wa_data;
               read_busy[i]              = 1'b0;
            end
            if (wb_live && (wb_addr == read_addr[i*AW +: AW])) begin
               read_data[i*XLEN +: XLEN] = wb_data;
               read_busy[i]              = 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default instance, a BYPASS=0 twin sharing its inputs, and a
// wide 4-port / 16-register / 64-bit instance.
module tb_register_file_mp;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  read_addr = '0;
   logic [63:0] rd0, rd1;
   logic [1:0]  rb0, rb1;
   logic        wa_enable = 1'b0, wb_enable = 1'b0, alloc_enable = 1'b0;
   logic [4:0]  wa_addr = '0, wb_addr = '0, alloc_addr = '0;
   logic [31:0] wa_data = '0, wb_data = '0;
   logic [31:0] bv0, bv1;

   logic [15:0]  w_read_addr = '0;
   logic [255:0] w_read_data;
   logic [3:0]   w_read_busy;
   logic         w_wa_enable = 1'b0, w_wb_enable = 1'b0, w_alloc_enable = 1'b0;
   logic [3:0]   w_wa_addr = '0, w_wb_addr = '0, w_alloc_addr = '0;
   logic [63:0]  w_wa_data = '0, w_wb_data = '0;
   logic [15:0]  w_busy_vec;

   int total = 0;
   int bad   = 0;

   register_file_mp #(.BYPASS(1)) dut0 (
      .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(rd0),
      .read_busy(rb0), .wa_enable(wa_enable), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
      .alloc_enable(alloc_enable), .alloc_addr(alloc_addr), .busy_vec(bv0));

   register_file_mp #(.BYPASS(0)) dut1 (
      .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(rd1),
      .read_busy(rb1), .wa_enable(wa_enable), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
      .alloc_enable(alloc_enable), .alloc_addr(alloc_addr), .busy_vec(bv1));

   register_file_mp #(.XLEN(64), .NREGS(16), .NUM_RD(4)) dut2 (
      .clock(clock), .reset(reset), .read_addr(w_read_addr), .read_data(w_read_data),
      .read_busy(w_read_busy), .wa_enable(w_wa_enable), .wa_addr(w_wa_addr),
      .wa_data(w_wa_data), .wb_enable(w_wb_enable), .wb_addr(w_wb_addr),
      .wb_data(w_wb_data), .alloc_enable(w_alloc_enable), .alloc_addr(w_alloc_addr),
      .busy_vec(w_busy_vec));

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #12 reset = 1'b0;
      read_addr = {5'd31, 5'd1};
      #1;
      total++; if (rd0 !== 64'h0 || bv0 !== 32'h0) begin
         bad++; $display("FAIL reset_state got data=%h busy=%h want 0/0", rd0, bv0);
      end
      for (int i = 1; i < 32; i++) begin
         wa_enable = 1'b1; wa_addr = 5'(i); wa_data = 32'hA000_0000 | 32'(i);
         tick();
      end
      wa_enable = 1'b0;
      alloc_enable = 1'b1; alloc_addr = 5'd3;
      tick();
      alloc_enable = 1'b0;
      total++; if (rd0[63:32] !== 32'hA000_001F || rd0[31:0] !== 32'hA000_0001) begin
         bad++; $display("FAIL fill_readback got %h want a000001fa0000001", rd0);
      end
      total++; if (bv0 !== 32'h0000_0008) begin
         bad++; $display("FAIL alloc_before_reset got %h want 00000008", bv0);
      end
      #2 reset = 1'b1;
      #1;
      total++; if (bv0 !== 32'h0 || bv1 !== 32'h0 || rb0 !== 2'b00) begin
         bad++; $display("FAIL busy_after_reset got %h/%h/%b want 0", bv0, bv1, rb0);
      end
      for (int i = 0; i < 32; i++) begin
         read_addr = {5'(31 - i), 5'(i)};
         #1;
         total++; if (rd0 !== 64'h0 || rd1 !== 64'h0) begin
            bad++; $display("FAIL reset_clears x%0d got %h/%h want 0", i, rd0, rd1);
         end
      end
      tick();
      #2 reset = 1'b0;
      tick();
   endtask

   task automatic test_dual_write();
      wa_enable = 1'b1; wa_addr = 5'd5; wa_data = 32'h1111_1111;
      wb_enable = 1'b1; wb_addr = 5'd5; wb_data = 32'h2222_2222;
      tick();
      wa_addr = 5'd6; wa_data = 32'h6666_0006;
      wb_addr = 5'd7; wb_data = 32'h7777_0007;
      tick();
      wa_enable = 1'b0; wb_enable = 1'b0;
      read_addr = {5'd5, 5'd5};
      #1;
      total++; if (rd0[31:0] !== 32'h2222_2222 || rd1[31:0] !== 32'h2222_2222) begin
         bad++; $display("FAIL collision_b_wins got %h/%h want 22222222", rd0[31:0], rd1[31:0]);
      end
      read_addr = {5'd7, 5'd6};
      #1;
      total++; if (rd0 !== 64'h7777_0007_6666_0006) begin
         bad++; $display("FAIL dual_commit got %h want 7777000766660006", rd0);
      end
   endtask

   task automatic test_bypass();
      wa_enable = 1'b1; wa_addr = 5'd9; wa_data = 32'h1234_5678;
      alloc_enable = 1'b1; alloc_addr = 5'd9;
      tick();
      alloc_enable = 1'b0;
      wa_data = 32'h8765_4321;
      read_addr = {5'd6, 5'd9};
      #1;
      total++; if (rd0[31:0] !== 32'h8765_4321 || rb0[0] !== 1'b0) begin
         bad++; $display("FAIL bypass_on got %h busy=%b want 87654321 busy=0", rd0[31:0], rb0[0]);
      end
      total++; if (rd1[31:0] !== 32'h1234_5678 || rb1[0] !== 1'b1) begin
         bad++; $display("FAIL bypass_off got %h busy=%b want 12345678 busy=1", rd1[31:0], rb1[0]);
      end
      total++; if (rd0[63:32] !== 32'h6666_0006) begin
         bad++; $display("FAIL bypass_other_port got %h want 66660006", rd0[63:32]);
      end
      wb_enable = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0055;
      #1;
      total++; if (rd0[31:0] !== 32'h0000_0055) begin
         bad++; $display("FAIL bypass_b_priority got %h want 00000055", rd0[31:0]);
      end
      tick();
      wa_enable = 1'b0; wb_enable = 1'b0;
      #1;
      total++; if (rd0[31:0] !== 32'h55 || rd1[31:0] !== 32'h55 || rb0[0] !== 1'b0 || rb1[0] !== 1'b0) begin
         bad++; $display("FAIL post_edge_x9 got %h/%h busy=%b%b want 55 busy=0", rd0[31:0], rd1[31:0], rb0[0], rb1[0]);
      end
   endtask

   task automatic test_scoreboard();
      read_addr = {5'd12, 5'd13};
      alloc_enable = 1'b1; alloc_addr = 5'd12;
      tick();
      total++; if (rb0 !== 2'b10 || bv0 !== 32'h0000_1000) begin
         bad++; $display("FAIL alloc_sets got rb=%b bv=%h want 10/00001000", rb0, bv0);
      end
      tick();
      alloc_enable = 1'b0;
      total++; if (bv0 !== 32'h0000_1000) begin
         bad++; $display("FAIL realloc_stays got %h want 00001000", bv0);
      end
      wb_enable = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0DE_000C;
      #1;
      total++; if (rb1[1] !== 1'b1 || rb0[1] !== 1'b0) begin
         bad++; $display("FAIL busy_before_edge got nb=%b byp=%b want 1/0", rb1[1], rb0[1]);
      end
      tick();
      wb_enable = 1'b0;
      total++; if (rb0[1] !== 1'b0 || bv0 !== 32'h0 || rd1[63:32] !== 32'hC0DE_000C) begin
         bad++; $display("FAIL wb_clears got rb=%b bv=%h d=%h want 0/0/c0de000c", rb0[1], bv0, rd1[63:32]);
      end
      alloc_enable = 1'b1; alloc_addr = 5'd12;
      wa_enable = 1'b1; wa_addr = 5'd12; wa_data = 32'h0;
      tick();
      alloc_enable = 1'b0;
      wa_addr = 5'd13;
      tick();
      wa_enable = 1'b0;
      total++; if (bv0 !== 32'h0000_1000 || rb1 !== 2'b10) begin
         bad++; $display("FAIL set_beats_clear got bv=%h rb=%b want 00001000/10", bv0, rb1);
      end
      wa_enable = 1'b1; wa_addr = 5'd12;
      tick();
      wa_enable = 1'b0;
      total++; if (bv0 !== 32'h0 || bv1 !== 32'h0) begin
         bad++; $display("FAIL wa_clears got %h/%h want 0", bv0, bv1);
      end
   endtask

   task automatic test_x0();
      wa_enable = 1'b1; wa_addr = 5'd0; wa_data = 32'hDEAD_BEEF;
      wb_enable = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
      alloc_enable = 1'b1; alloc_addr = 5'd0;
      read_addr = {5'd0, 5'd0};
      #1;
      total++; if (rd0 !== 64'h0 || rb0 !== 2'b00) begin
         bad++; $display("FAIL x0_no_bypass got %h busy=%b want 0/00", rd0, rb0);
      end
      tick();
      wa_enable = 1'b0; wb_enable = 1'b0; alloc_enable = 1'b0;
      #1;
      total++; if (rd0 !== 64'h0 || rd1 !== 64'h0 || rb0 !== 2'b00 || bv0 !== 32'h0) begin
         bad++; $display("FAIL x0_hardwired got %h/%h rb=%b bv=%h want 0", rd0, rd1, rb0, bv0);
      end
   endtask

   task automatic test_wide();
      w_wa_enable = 1'b1; w_wa_addr = 4'd15; w_wa_data = 64'hFFFF_FFFF_0000_0001;
      w_wb_enable = 1'b1; w_wb_addr = 4'd1;  w_wb_data = 64'h1111_2222_3333_4444;
      w_alloc_enable = 1'b1; w_alloc_addr = 4'd7;
      tick();
      w_alloc_enable = 1'b0;
      w_wa_addr = 4'd2; w_wa_data = 64'h0202_0202_0202_0202;
      w_wb_addr = 4'd3; w_wb_data = 64'h0303_0303_0303_0303;
      tick();
      w_wa_enable = 1'b0; w_wb_enable = 1'b0;
      w_read_addr = {4'd3, 4'd2, 4'd1, 4'd15};
      #1;
      total++; if (w_read_data[63:0] !== 64'hFFFF_FFFF_0000_0001) begin
         bad++; $display("FAIL wide_x15 got %h want ffffffff00000001", w_read_data[63:0]);
      end
      total++; if (w_read_data[255:64] !== {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h1111_2222_3333_4444}) begin
         bad++; $display("FAIL wide_ports got %h want 0303../0202../11112222..", w_read_data[255:64]);
      end
      w_read_addr = {4'd7, 4'd0, 4'd1, 4'd15};
      #1;
      total++; if (w_read_busy !== 4'b1000 || w_busy_vec !== 16'h0080 || w_read_data[255:192] !== 64'h0) begin
         bad++; $display("FAIL wide_busy got rb=%b bv=%h d=%h want 1000/0080/0", w_read_busy, w_busy_vec, w_read_data[255:192]);
      end
   endtask

   initial begin
      test_reset();
      test_dual_write();
      test_bypass();
      test_scoreboard();
      test_x0();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
